// File: rtl/chacha_pkg.sv
// chacha_pkg: shared ChaCha word/state types, sigma constants and round helpers
package chacha_pkg;
  typedef logic [31:0] word_t;
  typedef logic [15:0][31:0] state_t;
  typedef enum logic [1:0] {IDLE, ROUND, HOLD, DRAIN} fsm_t;
  localparam logic [3:0][31:0] SIGMA = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
  function automatic word_t rotl(word_t x, int n);
    return (x << n) | (x >> (32 - n));
  endfunction
  function automatic state_t quarter_round(state_t s, int a, int b, int c, int d);
    state_t t = s;
    t[a] = t[a] + t[b];
    t[d] = rotl(t[d] ^ t[a], 16);
    t[c] = t[c] + t[d];
    t[b] = rotl(t[b] ^ t[c], 12);
    t[a] = t[a] + t[b];
    t[d] = rotl(t[d] ^ t[a], 8);
    t[c] = t[c] + t[d];
    t[b] = rotl(t[b] ^ t[c], 7);
    return t;
  endfunction
  function automatic state_t init_state(logic [255:0] key, word_t counter, logic [95:0] nonce);
    return {nonce, counter, key, SIGMA};
  endfunction
endpackage

// File: rtl/chacha_dround.sv
// chacha_dround: DR_PER_CYC chained column+diagonal double rounds, purely combinational
module chacha_dround
  import chacha_pkg::*;
#(
  parameter int DR_PER_CYC = 1
) (
  input  state_t din,
  output state_t dout
);
  // apply the column round then the diagonal round, DR_PER_CYC times back to back
  always_comb begin
    dout = din;
    for (int i = 0; i < DR_PER_CYC; i++) begin
      dout = quarter_round(dout, 0, 4, 8, 12);
      dout = quarter_round(dout, 1, 5, 9, 13);
      dout = quarter_round(dout, 2, 6, 10, 14);
      dout = quarter_round(dout, 3, 7, 11, 15);
      dout = quarter_round(dout, 0, 5, 10, 15);
      dout = quarter_round(dout, 1, 6, 11, 12);
      dout = quarter_round(dout, 2, 7, 8, 13);
      dout = quarter_round(dout, 3, 4, 9, 14);
    end
  end
endmodule

// File: rtl/chacha_stream_gen.sv
// chacha_stream_gen: multi-block ChaCha keystream engine with backpressure, abort and counter-wrap guard; CHACHA_ZEROIZE_EN clears secrets after each job
module chacha_stream_gen
  import chacha_pkg::*;
#(
  parameter int ROUNDS     = 20,
  parameter int DR_PER_CYC = 1,
  parameter int NBLK_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [255:0]      key,
  input  logic [95:0]       nonce,
  input  logic [31:0]       counter_init,
  input  logic [NBLK_W-1:0] num_blocks,
  input  logic              abort,
  output logic              ks_valid,
  input  logic              ks_ready,
  output logic [511:0]      ks_data,
  output logic [31:0]       ks_counter,
  output logic              ks_last,
  output logic              busy,
  output logic              err_ctr_wrap
);
  localparam int N  = ROUNDS / (2 * DR_PER_CYC);
  localparam int CW = $clog2(N + 1);

  if (!(ROUNDS == 8 || ROUNDS == 12 || ROUNDS == 20)) begin : g_bad_rounds
    $error("chacha_stream_gen: ROUNDS must be 8, 12 or 20");
  end
  if (DR_PER_CYC < 1 || (ROUNDS / 2) % DR_PER_CYC != 0) begin : g_bad_dr
    $error("chacha_stream_gen: DR_PER_CYC must divide ROUNDS/2");
  end

  fsm_t              state, nxt;
  state_t            init_st, work_st, dr_out, sum;
  logic [CW-1:0]     rnd;
  logic [NBLK_W-1:0] rem;
  logic              accept, kill, out_free, last_rnd, write, more;

  chacha_dround #(.DR_PER_CYC(DR_PER_CYC)) u_dround (.din(work_st), .dout(dr_out));

  assign accept   = cfg_valid && cfg_ready && !abort;
  assign kill     = abort && state != IDLE;
  assign out_free = !ks_valid || ks_ready;
  assign last_rnd = rnd == CW'(N - 1);
  assign write    = !kill && out_free && ((state == ROUND && last_rnd) || state == HOLD);
  assign more     = rem > NBLK_W'(1) && init_st[12] != '1;

  // feed-forward: finished working state plus the initial state, word by word
  always_comb
    for (int i = 0; i < 16; i++) sum[i] = (state == HOLD ? work_st[i] : dr_out[i]) + init_st[i];

  // state register
  always_ff @(posedge clk or posedge reset)
    state <= reset ? IDLE : nxt;

  // next-state logic; abort outranks everything outside IDLE
  always_comb begin
    nxt = state;
    if (kill) nxt = IDLE;
    else
      case (state)
        IDLE:        if (accept) nxt = num_blocks == '0 ? DRAIN : ROUND;
        ROUND, HOLD: nxt = write ? (more ? ROUND : DRAIN) : (last_rnd ? HOLD : state);
        DRAIN:       if (out_free) nxt = IDLE;
        default:     nxt = IDLE;
      endcase
  end

  // FSM outputs
  always_comb begin
    cfg_ready = state == IDLE;
    busy      = state != IDLE;
  end

  // datapath: job latch, round iteration, output register and wrap flag
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      init_st      <= '0;
      work_st      <= '0;
      rnd          <= '0;
      rem          <= '0;
      ks_valid     <= 1'b0;
      ks_data      <= '0;
      ks_counter   <= '0;
      ks_last      <= 1'b0;
      err_ctr_wrap <= 1'b0;
    end else begin
      if (accept) begin
        init_st      <= init_state(key, counter_init, nonce);
        work_st      <= init_state(key, counter_init, nonce);
        rem          <= num_blocks;
        rnd          <= '0;
        err_ctr_wrap <= 1'b0;
      end else if (state == ROUND && !kill) begin
        work_st <= dr_out;
        rnd     <= rnd + CW'(1);
      end
      if (write) begin
        ks_data    <= sum;
        ks_counter <= init_st[12];
        ks_last    <= !more;
        rem        <= rem - NBLK_W'(1);
        if (more) begin
          init_st[12] <= init_st[12] + 32'd1;
          work_st     <= init_st;
          work_st[12] <= init_st[12] + 32'd1;
          rnd         <= '0;
        end
        if (rem > NBLK_W'(1) && init_st[12] == '1) err_ctr_wrap <= 1'b1;
      end
      ks_valid <= !kill && (write || (ks_valid && !ks_ready));
`ifdef CHACHA_ZEROIZE_EN
      if (kill || (state == DRAIN && ks_valid && ks_ready)) begin
        init_st    <= '0;
        work_st    <= '0;
        ks_data    <= '0;
        ks_counter <= '0;
        ks_last    <= 1'b0;
      end
`endif
    end
endmodule

// File: tb/tb_chacha_stream_gen.sv
// tb_chacha_stream_gen: directed checks of chacha_stream_gen (RFC 8439 vector, streaming, stall, wrap, abort, reset)
module tb_chacha_stream_gen;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cfg_valid = 1'b0, cfg_ready;
  logic [255:0] key;
  logic [95:0]  nonce = {32'h0, 32'h4a000000, 32'h09000000};
  logic [31:0]  counter_init = 32'd1;
  logic [15:0]  num_blocks = 16'd1;
  logic         abort = 1'b0;
  logic         ks_valid, ks_ready = 1'b0;
  logic [511:0] ks_data, blk;
  logic [31:0]  ks_counter;
  logic         ks_last, busy, err_ctr_wrap;
  int           checks = 0, errors = 0, cyc, seen;
`ifdef CHACHA_ZEROIZE_EN
  localparam bit ZEROIZE = 1'b1;
`else
  localparam bit ZEROIZE = 1'b0;
`endif

  chacha_stream_gen dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .key(key),
    .nonce(nonce), .counter_init(counter_init), .num_blocks(num_blocks), .abort(abort),
    .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data), .ks_counter(ks_counter),
    .ks_last(ks_last), .busy(busy), .err_ctr_wrap(err_ctr_wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotl(logic [31:0] v, int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic void qr(inout logic [31:0] x [16], input int a, input int b, input int c, input int d);
    x[a] += x[b]; x[d] = rotl(x[d] ^ x[a], 16);
    x[c] += x[d]; x[b] = rotl(x[b] ^ x[c], 12);
    x[a] += x[b]; x[d] = rotl(x[d] ^ x[a], 8);
    x[c] += x[d]; x[b] = rotl(x[b] ^ x[c], 7);
  endfunction

  function automatic logic [511:0] ref_block(logic [255:0] k, logic [31:0] c, logic [95:0] n);
    logic [31:0] s [16];
    logic [31:0] x [16];
    logic [511:0] r;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[32*i+:32];
    s[12] = c;
    for (int i = 0; i < 3; i++) s[13+i] = n[32*i+:32];
    x = s;
    for (int r2 = 0; r2 < 10; r2++) begin
      qr(x, 0, 4, 8, 12); qr(x, 1, 5, 9, 13); qr(x, 2, 6, 10, 14); qr(x, 3, 7, 11, 15);
      qr(x, 0, 5, 10, 15); qr(x, 1, 6, 11, 12); qr(x, 2, 7, 8, 13); qr(x, 3, 4, 9, 14);
    end
    for (int i = 0; i < 16; i++) r[32*i+:32] = x[i] + s[i];
    return r;
  endfunction

  task automatic check(string tag, logic [511:0] obs, logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(logic [31:0] c, logic [15:0] n);
    counter_init = c;
    num_blocks   = n;
    cfg_valid    = 1'b1;
    @(negedge clk);
    cfg_valid    = 1'b0;
  endtask

  task automatic wait_valid(string tag, int lim);
    for (int i = 0; i < lim && !ks_valid; i++) @(negedge clk);
    check(tag, ks_valid, 1);
  endtask

  initial begin
    for (int j = 0; j < 32; j++) key[8*j+:8] = 8'(j);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_ks_valid", ks_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_ctr_wrap, 0);
    check("rst_ks_data", ks_data, 0);
    check("rst_ks_last", ks_last, 0);
    check("rst_ks_counter", ks_counter, 0);

    ks_ready = 1'b0;
    counter_init = 32'd1; num_blocks = 16'd1; cfg_valid = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cfg_valid = 1'b0;
      cyc++;
    end while (!ks_valid && cyc < 40);
    check("rfc_latency", cyc, 11);
    check("rfc_w0", ks_data[31:0], 32'he4e7f110);
    check("rfc_w1", ks_data[63:32], 32'h15593bd1);
    check("rfc_w15", ks_data[511:480], 32'h4e3c50a2);
    check("rfc_model", ks_data, ref_block(key, 32'd1, nonce));
    check("rfc_counter", ks_counter, 1);
    check("rfc_last", ks_last, 1);
    check("rfc_busy", busy, 1);
    blk = ks_data;
    ks_ready = 1'b1;
    @(negedge clk);
    ks_ready = 1'b0;
    check("rfc_done_cfg_ready", cfg_ready, 1);
    check("rfc_done_valid", ks_valid, 0);
    check("rfc_done_data", ks_data, ZEROIZE ? 512'd0 : blk);

    start_job(32'd1, 16'd4);
    wait_valid("stall_first", 20);
    blk = ks_data;
    repeat (30) @(negedge clk);
    check("stall_valid", ks_valid, 1);
    check("stall_data", ks_data, blk);
    check("stall_counter", ks_counter, 1);
    check("stall_last", ks_last, 0);
    ks_ready = 1'b1;
    for (int b = 1; b <= 4; b++) begin
      wait_valid($sformatf("stream_valid%0d", b), 30);
      check($sformatf("stream_counter%0d", b), ks_counter, 32'(b));
      check($sformatf("stream_data%0d", b), ks_data, ref_block(key, 32'(b), nonce));
      check($sformatf("stream_last%0d", b), ks_last, b == 4);
      @(negedge clk);
    end
    check("stream_cfg_ready", cfg_ready, 1);
    check("stream_no_extra", ks_valid, 0);

    start_job(32'hFFFFFFFE, 16'd4);
    for (int b = 0; b < 2; b++) begin
      wait_valid($sformatf("wrap_valid%0d", b), 30);
      check($sformatf("wrap_counter%0d", b), ks_counter, 32'hFFFFFFFE + 32'(b));
      check($sformatf("wrap_data%0d", b), ks_data, ref_block(key, 32'hFFFFFFFE + 32'(b), nonce));
      check($sformatf("wrap_last%0d", b), ks_last, b == 1);
      @(negedge clk);
    end
    check("wrap_cfg_ready", cfg_ready, 1);
    check("wrap_err", err_ctr_wrap, 1);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      seen += int'(ks_valid);
    end
    check("wrap_no_more_blocks", seen, 0);
    check("wrap_err_sticky", err_ctr_wrap, 1);

    start_job(32'd7, 16'd0);
    check("zero_err_cleared", err_ctr_wrap, 0);
    check("zero_cfg_ready_low", cfg_ready, 0);
    check("zero_no_valid", ks_valid, 0);
    @(negedge clk);
    check("zero_cfg_ready_back", cfg_ready, 1);
    check("zero_no_valid2", ks_valid, 0);

    abort = 1'b1; cfg_valid = 1'b1;
    @(negedge clk);
    abort = 1'b0; cfg_valid = 1'b0;
    check("idle_abort_cfg_rejected", cfg_ready, 1);
    check("idle_abort_busy", busy, 0);

    ks_ready = 1'b1;
    start_job(32'd1, 16'd3);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_round_valid", ks_valid, 0);
    check("abort_round_cfg_ready", cfg_ready, 1);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      seen += int'(ks_valid);
    end
    check("abort_round_no_blocks", seen, 0);

    ks_ready = 1'b0;
    start_job(32'd1, 16'd2);
    wait_valid("abort_pend_valid", 20);
    abort = 1'b1; ks_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0; ks_ready = 1'b0;
    check("abort_pend_valid_low", ks_valid, 0);
    check("abort_pend_cfg_ready", cfg_ready, 1);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      seen += int'(ks_valid);
    end
    check("abort_pend_no_blocks", seen, 0);

    start_job(32'd5, 16'd3);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("areset_cfg_ready", cfg_ready, 1);
    check("areset_busy", busy, 0);
    check("areset_valid", ks_valid, 0);
    check("areset_data", ks_data, 0);
    check("areset_counter", ks_counter, 0);
    check("areset_last", ks_last, 0);
    check("areset_err", err_ctr_wrap, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/chacha_stream_gen.md
Name: chacha_stream_gen

Overview:
Parametrised ChaCha keystream engine; successor to the single-block ChaCha20 top level. Accepts one job (key, nonce, initial counter, block count) over a valid/ready config handshake. Streams consecutive 512-bit keystream blocks with auto-incremented counter over a valid/ready output port, with backpressure, abort and counter-overflow protection. Round count is configurable (ChaCha8/12/20), and so is the number of double rounds per clock.

Parameters:
ROUNDS, 20, total rounds; must be 8, 12 or 20 (elaboration error otherwise)
DR_PER_CYC, 1, double rounds per clock; must divide ROUNDS/2 (elaboration error otherwise)
NBLK_W, 16, width of the block-count field

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
cfg_valid  in  1  job request
cfg_ready  out  1  engine idle, job accepted when cfg_valid&cfg_ready
key  in  256  key, word i = key[32i+:32], little-endian words per RFC 8439
nonce  in  96  nonce, word i = nonce[32i+:32]
counter_init  in  32  block counter of first block
num_blocks  in  NBLK_W  blocks requested
abort  in  1  synchronous job cancel
ks_valid  out  1  keystream block available
ks_ready  in  1  consumer accepts block
ks_data  out  512  keystream, word i = ks_data[32i+:32]
ks_counter  out  32  counter value used for ks_data
ks_last  out  1  final block of job
busy  out  1  job in progress or output pending
err_ctr_wrap  out  1  sticky: job truncated at counter 0xFFFFFFFF; cleared by next accepted cfg or reset

Behaviour:
- Reset: all outputs 0 except cfg_ready=1; FSM=IDLE; key/state/output registers cleared.
- Latency: N = ROUNDS/(2*DR_PER_CYC) round cycles.
- FSM states:
  - IDLE: cfg_ready=1. Config handshake in cycle T latches key/nonce/counter/num_blocks, builds the initial state (sigma, key, counter, nonce) and moves to ROUND.
  - ROUND: one chacha_dround step per cycle for N cycles. On the last cycle, the working state plus the initial state (mod 2^32 per word) is written to the output register if it is empty or being drained that same cycle; otherwise the FSM goes to HOLD.
  - HOLD: wait for output register to be free, then write it.
  - After each write: remaining count decrements. If more blocks remain, counter += 1 and ROUND restarts in the next cycle; otherwise the FSM goes to DRAIN.
  - DRAIN: wait for final handshake, then IDLE.
- First ks_valid in cycle T+N+1 (ROUNDS=20, DR_PER_CYC=1: T+11). Sustained throughput with ks_ready=1 is one block per N cycles.
- Output handshake: ks_valid stays high until ks_ready. ks_data, ks_counter and ks_last stay stable while ks_valid&!ks_ready.
- ks_last=1 on the final block.
- busy = !cfg_ready.
- num_blocks=0: job accepted, no output, FSM back to IDLE the next cycle.
- Counter wrap: if the block with counter 0xFFFFFFFF is written and blocks remain, that block gets ks_last=1 and err_ctr_wrap is set. No counter-0 block is generated.
- Abort (any state except IDLE): next cycle FSM=IDLE, ks_valid=0, and any pending block is discarded. Abort wins over a simultaneous ks_ready. Abort in IDLE is ignored. cfg_valid in the same cycle as abort is not accepted.
- Asynchronous reset mid-job: immediate return to reset values.

Optional Feature:
- Macro: CHACHA_ZEROIZE_EN.
- Defined: in the cycle after a job ends (last handshake or abort), the key, initial state, working state and output registers are cleared to 0, so ks_data reads 0 in IDLE.
- Undefined: registers retain their last contents; ks_data holds the last block.

Decomposition:
- Shared package chacha_pkg:
  - word_t (32-bit) and state_t (16 x word_t)
  - SIGMA constants 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574
  - function quarter_round
  - function init_state(key, counter, nonce)
- Sub-module chacha_dround: combinational, DR_PER_CYC chained column+diagonal double rounds, state_t in and out.

Test Plan:
- RFC 8439 2.3.2 vector: key 00..1f, nonce 000000090000004a00000000, counter_init 1, num_blocks 1 -> ks_data word0=0xe4e7f110, word1=0x15593bd1, word15=0x4e3c50a2; ks_counter=1; ks_last=1; ks_valid at T+11.
- Same vector with DR_PER_CYC=2 -> identical data, ks_valid at T+6. ROUNDS=8 build -> matches the software model.
- num_blocks=4, ks_ready low for 30 cycles then 1 -> no loss, ks_counter 1,2,3,4, data stable while stalled, ks_last only on counter 4, cfg_ready=1 after the final handshake.
- counter_init 0xFFFFFFFE, num_blocks 4 -> exactly 2 blocks (counters FFFFFFFE, FFFFFFFF), ks_last on the second, err_ctr_wrap=1 until next cfg accept.
- Abort in ROUND cycle 5, and abort together with ks_ready during pending output -> next cycle ks_valid=0, cfg_ready=1, no further blocks; num_blocks=0 -> no ks_valid, cfg_ready back after 1 cycle.
- Async reset asserted mid-ROUND -> all outputs at reset values immediately. With CHACHA_ZEROIZE_EN, ks_data=0 after the final handshake; without it, ks_data holds the last block.
